// File: rtl/parity_link_pkg.sv
// Shared definitions for the 4-bit parity-protected serial link.
package parity_link_pkg;

    localparam int   LINK_DATA_W = 4;

    // Line levels for the frame delimiters and the idle line.
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/parity_calc.sv
// Link parity rule: p = ~(d0 ^ d1 ^ ... ^ dN). Both link ends use this block
// so the transmitter and receiver always agree on the parity.
module parity_calc #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] i_data,
    output logic              o_parity
);

    assign o_parity = ~^i_data;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, DATA_W data bits (LSB first), parity, stop.
// Presents the word with parity/framing status and keeps a saturating
// count of bad frames.
module serial_parity_rx
    import parity_link_pkg::*;
#(
    parameter int DATA_W = LINK_DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              serial_in,
    input  logic              clr_count,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    rx_state_t         r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic [DATA_W-1:0] r_data;
    logic              r_dvalid;
    logic              r_perr;
    logic              r_ferr;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_par_calc;
    logic              w_done;
    logic              w_perr;
    logic              w_ferr;

    parity_calc #(.DATA_W(DATA_W)) u_parity (
        .i_data   (r_shift),
        .o_parity (w_par_calc)
    );

    // In STOP the shift register already holds the full word, so the
    // frame status can be resolved on the same strobe that samples the stop bit.
    assign w_done = bit_valid && (r_state == STOP);
    assign w_perr = (r_par != w_par_calc);
    assign w_ferr = (serial_in != STOP_BIT);

    // Frame FSM: walks start/data/parity/stop on strobed bits, registers results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_data   <= '0;
            r_dvalid <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_dvalid <= 1'b0;
            if (bit_valid) begin
                case (r_state)
                    IDLE: begin
                        if (serial_in == START_BIT) begin
                            r_state <= DATA;
                            r_idx   <= '0;
                        end
                    end
                    DATA: begin
                        // LSB arrives first: shift right, new bit enters at the top.
                        r_shift <= (r_shift >> 1) | (DATA_W'(serial_in) << (DATA_W - 1));
                        if (r_idx == LAST_IDX) begin
                            r_state <= PARITY;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                    PARITY: begin
                        r_par   <= serial_in;
                        r_state <= STOP;
                    end
                    STOP: begin
                        r_data   <= r_shift;
                        r_perr   <= w_perr;
                        r_ferr   <= w_ferr;
                        r_dvalid <= 1'b1;
                        r_state  <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Saturating bad-frame counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_count) begin
            r_cnt <= '0;
        end else if (w_done && (w_perr || w_ferr) && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_dvalid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign err_count  = r_cnt;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Self-checking bench for serial_parity_rx: table of directed frames,
// hand-written corner sequences and randomized frames against a model.
module tb_serial_parity_rx;

    localparam int DW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          bit_valid;
    logic          serial_in;
    logic          clr_count;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic [CW-1:0] err_count;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference state: what the outputs must show after the last completed frame.
    int          m_cnt  = 0;
    logic [DW-1:0] m_data = '0;

    typedef struct {
        logic [DW-1:0] dout;
        logic          perr;
        logic          ferr;
        logic [CW-1:0] cnt;
        int            cyc;
    } obs_t;
    obs_t q[$];

    typedef struct {
        logic [DW-1:0] d;
        logic          p;
        logic          stop;
        int            gap;
        logic [DW-1:0] exp_dout;
        logic          exp_perr;
        logic          exp_ferr;
    } vec_t;

    serial_parity_rx #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .serial_in  (serial_in),
        .clr_count  (clr_count),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every data_valid pulse with the outputs it qualifies.
    always @(negedge clk) begin
        if (data_valid) begin
            obs_t o;
            o.dout = data_out;
            o.perr = parity_err;
            o.ferr = frame_err;
            o.cnt  = err_count;
            o.cyc  = cyc;
            q.push_back(o);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One strobed line bit; between strobes the line carries noise.
    task automatic send_bit(input logic b);
        serial_in = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        serial_in = 1'($urandom);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stop,
                              input int gap, input logic clr_on_stop);
        logic [6:0] bits;
        bits = {stop, p, d, 1'b0};
        for (int i = 0; i < 7; i++) begin
            if (i == 6 && clr_on_stop) clr_count = 1'b1;
            send_bit(bits[i]);
            clr_count = 1'b0;
            if (i < 6) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    // Model: correct parity is 1 exactly when the word has an even number of ones.
    task automatic model_frame(input logic [DW-1:0] d, input logic p, input logic stop,
                               input logic clr, output logic perr, output logic ferr);
        logic good_p;
        good_p = (($countones(d) % 2) == 0);
        perr   = (p != good_p);
        ferr   = (stop == 1'b0);
        m_data = d;
        if (clr) m_cnt = 0;
        else if ((perr || ferr) && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    endtask

    task automatic expect_frame(input string name, input logic [DW-1:0] dout,
                                input logic perr, input logic ferr);
        obs_t o;
        @(negedge clk);
        #1;
        chk({name, ".pulses"}, q.size(), 1);
        if (q.size() > 0) begin
            o = q.pop_front();
            chk({name, ".data_out"},   o.dout, dout);
            chk({name, ".parity_err"}, o.perr, perr);
            chk({name, ".frame_err"},  o.ferr, ferr);
            chk({name, ".err_count"},  o.cnt,  m_cnt);
        end
        q.delete();
        chk({name, ".busy"}, busy, 1'b0);
        @(negedge clk);
        #1;
        chk({name, ".valid_1cyc"}, data_valid, 1'b0);
    endtask

    task automatic run_frame(input string name, input logic [DW-1:0] d, input logic p,
                             input logic stop, input int gap, input logic clr);
        logic pe, fe;
        send_frame(d, p, stop, gap, clr);
        model_frame(d, p, stop, clr, pe, fe);
        expect_frame(name, m_data, pe, fe);
    endtask

    vec_t vecs[6];
    obs_t a, b;

    initial begin
        rst = 1'b1; bit_valid = 1'b0; serial_in = 1'b1; clr_count = 1'b0;

        // Directed frames with hand-derived results.
        vecs[0] = '{4'b1011, 1'b0, 1'b1, 0, 4'hB, 1'b0, 1'b0};
        vecs[1] = '{4'b0011, 1'b0, 1'b1, 0, 4'h3, 1'b1, 1'b0};
        vecs[2] = '{4'b0000, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b1};
        vecs[3] = '{4'b1011, 1'b0, 1'b1, 3, 4'hB, 1'b0, 1'b0};
        vecs[4] = '{4'b1111, 1'b1, 1'b1, 1, 4'hF, 1'b0, 1'b0};
        vecs[5] = '{4'b0111, 1'b1, 1'b1, 2, 4'h7, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst.data_out",   data_out,   '0);
        chk("rst.data_valid", data_valid, 1'b0);
        chk("rst.parity_err", parity_err, 1'b0);
        chk("rst.frame_err",  frame_err,  1'b0);
        chk("rst.err_count",  err_count,  '0);
        chk("rst.busy",       busy,       1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            logic pe, fe;
            send_frame(vecs[i].d, vecs[i].p, vecs[i].stop, vecs[i].gap, 1'b0);
            model_frame(vecs[i].d, vecs[i].p, vecs[i].stop, 1'b0, pe, fe);
            expect_frame($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_perr, vecs[i].exp_ferr);
        end

        // Busy rises after start detection.
        send_bit(1'b0);
        chk("start.busy", busy, 1'b1);
        // Reset after two data bits: partial frame discarded.
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("midrst.busy",      busy,      1'b0);
        chk("midrst.err_count", err_count, '0);
        chk("midrst.pulses",    q.size(),  0);
        m_cnt = 0; m_data = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame("after_rst", 4'h6, 1'b1, 1'b1, 0, 1'b0);

        // Saturation of the error counter.
        for (int i = 0; i < 260; i++) run_frame("flood", 4'h3, 1'b0, 1'b1, 0, 1'b0);
        chk("flood.sat", err_count, 8'd255);
        // Clear in the same cycle as an error increment.
        run_frame("clr_vs_inc", 4'h3, 1'b0, 1'b1, 0, 1'b1);
        chk("clr.err_count", err_count, '0);

        // Idle line, then two back-to-back good frames.
        serial_in = 1'b1; bit_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("idle.busy", busy, 1'b0);
        end
        chk("idle.pulses", q.size(), 0);
        send_frame(4'h5, 1'b1, 1'b1, 0, 1'b0);
        send_frame(4'hA, 1'b1, 1'b1, 0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("b2b.pulses", q.size(), 2);
        if (q.size() == 2) begin
            a = q[0]; b = q[1];
            chk("b2b.first",  a.dout, 4'h5);
            chk("b2b.second", b.dout, 4'hA);
            chk("b2b.spacing", b.cyc - a.cyc, 7);
            chk("b2b.errs", {a.perr, a.ferr, b.perr, b.ferr}, 4'b0000);
        end
        q.delete();
        chk("b2b.data_out", data_out, 4'hA);

        // Randomized frames against the model.
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] d;
            logic p, s;
            int g;
            d = DW'($urandom_range(0, 15));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 4) != 0);
            g = $urandom_range(0, 2);
            run_frame($sformatf("rnd%0d", i), d, p, s, g, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
